// File: rtl/bus_access_multi.sv
// Captures c-, g- and p-access reads from the VIC-II data bus and keeps a
// runtime-sized character line buffer shared by the 40- and 80-column modes.
module bus_access_multi #(
  parameter int NUM_SPRITES = 8,
  parameter int MAX_COLS    = 80,
  parameter int CNT_W       = 7,
  parameter int DATA_W      = 12,
  parameter int PIX_W       = 8,
  parameter int CLEAR_CYCLE = 55
) (
  input  logic                         clk_dot4x,
  input  logic                         rst_n,
  input  logic                         phi_phase_start_dav,
  input  logic                         phi_phase_start_pixel_latch,
  input  logic                         clk_phi,
  input  logic [3:0]                   cycle_type,
  input  logic [6:0]                   cycle_num,
  input  logic                         aec,
  input  logic [DATA_W-1:0]            dbi,
  input  logic                         idle,
  input  logic [2:0]                   sprite_cnt,
  input  logic [NUM_SPRITES-1:0]       sprite_dma,
  input  logic [CNT_W-1:0]             num_cols,
  input  logic                         line_start,
  input  logic                         clr_status,
  output logic [NUM_SPRITES*PIX_W-1:0] sprite_ptr_o,
  output logic [PIX_W-1:0]             pixels_read,
  output logic [DATA_W-1:0]            char_read,
  output logic [DATA_W-1:0]            char_next,
  output logic                         char_valid,
  output logic                         buf_overrun
);

  // Cycle type codes shared with the rest of the VIC-II datapath.
  localparam logic [3:0] VIC_LP  = 4'd0;
  localparam logic [3:0] VIC_LG  = 4'd4;
  localparam logic [3:0] VIC_HRC = 4'd10;
  localparam logic [3:0] VIC_HGC = 4'd11;
  localparam logic [3:0] VIC_HGI = 4'd12;
  localparam logic [3:0] VIC_HRX = 4'd15;

  localparam logic [CNT_W:0] MAX_COLS_W = (CNT_W+1)'(MAX_COLS);

  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [CNT_W-1:0]  idx;
  logic [CNT_W:0]    ncols;
  logic              wrapped;
  logic              wrapped_nxt;
  logic              at_last;
  logic              fetch_acc;
  logic              cache_acc;
  logic              access;
  logic              overrun_set;
  logic              g_acc;
  logic              p_acc;
  logic              pix_clear;
  logic [DATA_W-1:0] fetch_word;
  logic [DATA_W-1:0] cached_word;
  logic [DATA_W-1:0] line_buf [MAX_COLS];
  logic [PIX_W-1:0]  ptr [NUM_SPRITES];

  always_comb begin
    if (num_cols == '0 || {1'b0, num_cols} > MAX_COLS_W) begin
      ncols = MAX_COLS_W;
    end else begin
      ncols = {1'b0, num_cols};
    end
  end

  always_comb begin
    fetch_acc   = phi_phase_start_dav && (cycle_type == VIC_HRC || cycle_type == VIC_HGC);
    cache_acc   = phi_phase_start_dav && (cycle_type == VIC_HRX || cycle_type == VIC_HGI);
    access      = fetch_acc || cache_acc;
    g_acc       = !aec && phi_phase_start_dav && cycle_type == VIC_LG;
    p_acc       = !aec && phi_phase_start_dav && cycle_type == VIC_LP;
    pix_clear   = clk_phi && phi_phase_start_pixel_latch && cycle_num == 7'(CLEAR_CYCLE);
    idx         = line_start ? '0 : cnt;
    // While the bus belongs to the CPU the character byte floats high.
    fetch_word  = {dbi[DATA_W-1:PIX_W], aec ? {PIX_W{1'b1}} : dbi[PIX_W-1:0]};
    cached_word = line_buf[idx];
    // ">=" rather than "==" so a shrink of num_cols below cnt still wraps.
    at_last     = {1'b0, idx} >= (ncols - (CNT_W+1)'(1));
    overrun_set = access && wrapped && !line_start;
  end

  always_comb begin
    cnt_nxt     = cnt;
    wrapped_nxt = wrapped;
    if (line_start) begin
      cnt_nxt     = '0;
      wrapped_nxt = 1'b0;
    end
    if (access) begin
      if (at_last) begin
        cnt_nxt     = '0;
        wrapped_nxt = 1'b1;
      end else begin
        cnt_nxt = idx + CNT_W'(1);
      end
    end
  end

  // Buffer contents are not reset; they are always written before being read.
  always_ff @(posedge clk_dot4x) begin
    if (fetch_acc) begin
      line_buf[idx] <= fetch_word;
    end
  end

  always_ff @(posedge clk_dot4x or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      wrapped     <= 1'b0;
      buf_overrun <= 1'b0;
      char_next   <= '0;
      char_valid  <= 1'b0;
      char_read   <= '0;
      pixels_read <= '0;
    end else begin
      cnt        <= cnt_nxt;
      wrapped    <= wrapped_nxt;
      char_valid <= access;
      if (fetch_acc) begin
        char_next <= fetch_word;
      end else if (cache_acc) begin
        char_next <= cached_word;
      end
      if (overrun_set) begin
        buf_overrun <= 1'b1;
      end else if (clr_status) begin
        buf_overrun <= 1'b0;
      end
      if (g_acc) begin
        char_read <= idle ? '0 : char_next;
      end
      if (pix_clear) begin
        pixels_read <= '0;
      end else if (g_acc) begin
        pixels_read <= dbi[PIX_W-1:0];
      end
    end
  end

  // Matching on the loop index keeps out-of-range sprite_cnt values inert.
  always_ff @(posedge clk_dot4x or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        ptr[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        if (p_acc && sprite_cnt == 3'(i)) begin
          ptr[i] <= sprite_dma[i] ? dbi[PIX_W-1:0] : {PIX_W{1'b1}};
        end
      end
    end
  end

  always_comb begin
    sprite_ptr_o = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      sprite_ptr_o[(NUM_SPRITES-1-i)*PIX_W +: PIX_W] = ptr[i];
    end
  end

endmodule

// File: tb/tb_bus_access_multi.sv
// Bench for bus_access_multi: scoreboarded char_next stream plus targeted
// checks of counter wrap, overrun, g-access, pixel clear and sprite pointers.
module tb_bus_access_multi;

  localparam logic [3:0] VIC_LP  = 4'd0;
  localparam logic [3:0] VIC_LG  = 4'd4;
  localparam logic [3:0] VIC_HRC = 4'd10;
  localparam logic [3:0] VIC_HGC = 4'd11;
  localparam logic [3:0] VIC_HGI = 4'd12;
  localparam logic [3:0] VIC_HRX = 4'd15;
  localparam logic [3:0] VIC_HI  = 4'd13;

  // clock / reset
  logic clk_dot4x = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk_dot4x = ~clk_dot4x;

  logic        phi_phase_start_dav = 1'b0;
  logic        phi_phase_start_pixel_latch = 1'b0;
  logic        clk_phi = 1'b0;
  logic [3:0]  cycle_type = VIC_HI;
  logic [6:0]  cycle_num = 7'd0;
  logic        aec = 1'b0;
  logic [11:0] dbi = 12'h000;
  logic        idle = 1'b0;
  logic [2:0]  sprite_cnt = 3'd0;
  logic [7:0]  sprite_dma = 8'h00;
  logic [6:0]  num_cols = 7'd0;
  logic        line_start = 1'b0;
  logic        clr_status = 1'b0;
  logic [63:0] sprite_ptr_o;
  logic [7:0]  pixels_read;
  logic [11:0] char_read;
  logic [11:0] char_next;
  logic        char_valid;
  logic        buf_overrun;

  bus_access_multi dut (
    .clk_dot4x(clk_dot4x), .rst_n(rst_n),
    .phi_phase_start_dav(phi_phase_start_dav),
    .phi_phase_start_pixel_latch(phi_phase_start_pixel_latch),
    .clk_phi(clk_phi), .cycle_type(cycle_type), .cycle_num(cycle_num),
    .aec(aec), .dbi(dbi), .idle(idle), .sprite_cnt(sprite_cnt),
    .sprite_dma(sprite_dma), .num_cols(num_cols), .line_start(line_start),
    .clr_status(clr_status), .sprite_ptr_o(sprite_ptr_o),
    .pixels_read(pixels_read), .char_read(char_read), .char_next(char_next),
    .char_valid(char_valid), .buf_overrun(buf_overrun)
  );

  int n_cmp = 0;
  int n_err = 0;
  int valid_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard for the char_next stream
  logic [11:0] exp_q[$];

  always @(negedge clk_dot4x) begin
    if (rst_n && char_valid) begin
      valid_cnt++;
      if (exp_q.size() == 0) begin
        check("char_valid_unexpected", 64'(char_next), 64'hFFFF_FFFF);
      end else begin
        check("char_next", 64'(char_next), 64'(exp_q.pop_front()));
      end
    end
  end

  // reference model of the line buffer / counter / overrun
  logic [11:0] m_buf [80];
  int          m_cnt = 0;
  logic        m_wrapped = 1'b0;
  logic        m_ovr = 1'b0;
  logic [7:0]  m_ptr [8];

  function automatic int ncols_f();
    int n = int'(num_cols);
    return (n == 0 || n > 80) ? 80 : n;
  endfunction

  function automatic logic [63:0] ptr_vec();
    logic [63:0] v = '0;
    for (int i = 0; i < 8; i++) v[(7-i)*8 +: 8] = m_ptr[i];
    return v;
  endfunction

  // drive one bus cycle; strobes drop 1 ns after the edge
  task automatic bus_cycle(input logic [3:0] ct, input logic [11:0] d, input logic a,
                           input logic dav, input logic ls, input logic clr);
    logic        fetch, cached;
    int          idx;
    logic [11:0] w;
    @(negedge clk_dot4x);
    cycle_type = ct; dbi = d; aec = a; phi_phase_start_dav = dav;
    line_start = ls; clr_status = clr;
    fetch  = dav && (ct == VIC_HRC || ct == VIC_HGC);
    cached = dav && (ct == VIC_HRX || ct == VIC_HGI);
    if (fetch || cached) begin
      idx = ls ? 0 : m_cnt;
      if (fetch) begin
        w = {d[11:8], a ? 8'hFF : d[7:0]};
        m_buf[idx] = w;
      end else begin
        w = m_buf[idx];
      end
      exp_q.push_back(w);
      if (m_wrapped && !ls) m_ovr = 1'b1;
      else if (clr) m_ovr = 1'b0;
      if (ls) m_wrapped = 1'b0;
      if (idx >= ncols_f() - 1) begin
        m_cnt = 0;
        m_wrapped = 1'b1;
      end else begin
        m_cnt = idx + 1;
      end
    end else begin
      if (ls) begin
        m_cnt = 0;
        m_wrapped = 1'b0;
      end
      if (clr) m_ovr = 1'b0;
    end
    @(posedge clk_dot4x);
    #1;
    phi_phase_start_dav = 1'b0; line_start = 1'b0; clr_status = 1'b0;
    cycle_type = VIC_HI;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8; i++) m_ptr[i] = 8'h00;
    repeat (3) @(posedge clk_dot4x);
    #1;
    check("rst_char_next", 64'(char_next), 64'h0);
    check("rst_char_valid", 64'(char_valid), 64'h0);
    check("rst_ptrs", sprite_ptr_o, 64'h0);
    check("rst_pixels", 64'(pixels_read), 64'h0);
    @(negedge clk_dot4x);
    rst_n = 1'b1;

    // reset mid-line after 10 fetches and a sprite load
    num_cols = 7'd0;
    bus_cycle(VIC_HI, 12'h000, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int n = 0; n < 10; n++) bus_cycle(VIC_HRC, 12'(12'h100 + n), 1'b0, 1'b1, 1'b0, 1'b0);
    sprite_cnt = 3'd0; sprite_dma = 8'h01;
    bus_cycle(VIC_LP, 12'h011, 1'b0, 1'b1, 1'b0, 1'b0);
    m_ptr[0] = 8'h11;
    check("pre_rst_cnt", 64'(dut.cnt), 64'(m_cnt));
    check("pre_rst_ptrs", sprite_ptr_o, ptr_vec());
    #2;
    rst_n = 1'b0;
    #1;
    m_cnt = 0; m_wrapped = 1'b0; m_ovr = 1'b0; m_ptr[0] = 8'h00;
    check("async_rst_cnt", 64'(dut.cnt), 64'h0);
    check("async_rst_char_next", 64'(char_next), 64'h0);
    check("async_rst_ptrs", sprite_ptr_o, 64'h0);
    check("async_rst_ovr", 64'(buf_overrun), 64'h0);
    check("queue_drained_1", 64'(exp_q.size()), 64'h0);
    @(negedge clk_dot4x);
    rst_n = 1'b1;

    // 40-column badline then cached replay
    valid_cnt = 0;
    num_cols = 7'd40;
    bus_cycle(VIC_HI, 12'h000, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int n = 0; n < 40; n++) bus_cycle(VIC_HRC, 12'(12'hA00 + n), 1'b0, 1'b1, 1'b0, 1'b0);
    check("wrap40_cnt", 64'(dut.cnt), 64'h0);
    bus_cycle(VIC_HI, 12'h000, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int n = 0; n < 40; n++) bus_cycle(VIC_HGI, 12'h000, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk_dot4x); #1;
    check("valid_pulses_80", 64'(valid_cnt), 64'd80);
    check("ovr_after_40col", 64'(buf_overrun), 64'(m_ovr));

    // aec high during fetch, then g-accesses with idle on/off
    bus_cycle(VIC_HI, 12'h000, 1'b0, 1'b0, 1'b1, 1'b0);
    bus_cycle(VIC_HRC, 12'h5C3, 1'b1, 1'b1, 1'b0, 1'b0);
    idle = 1'b1; cycle_num = 7'd10; clk_phi = 1'b1; phi_phase_start_pixel_latch = 1'b1;
    bus_cycle(VIC_LG, 12'h081, 1'b0, 1'b1, 1'b0, 1'b0);
    check("g_idle_char_read", 64'(char_read), 64'h0);
    check("g_pixels", 64'(pixels_read), 64'h81);
    idle = 1'b0;
    bus_cycle(VIC_LG, 12'h042, 1'b1, 1'b1, 1'b0, 1'b0);
    check("g_aec_high_no_load", 64'(pixels_read), 64'h81);
    bus_cycle(VIC_LG, 12'h0C7, 1'b0, 1'b1, 1'b0, 1'b0);
    check("g_char_read", 64'(char_read), 64'h5FF);
    check("g_pixels_2", 64'(pixels_read), 64'hC7);
    bus_cycle(VIC_HRX, 12'h000, 1'b0, 1'b1, 1'b1, 1'b0);

    // overrun with num_cols=0 (80 columns)
    num_cols = 7'd0;
    bus_cycle(VIC_HI, 12'h000, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int n = 0; n < 80; n++) bus_cycle(VIC_HRC, 12'($urandom_range(0, 4095)), 1'b0, 1'b1, 1'b0, 1'b0);
    check("ovr_after_80", 64'(buf_overrun), 64'h0);
    bus_cycle(VIC_HRC, 12'($urandom_range(0, 4095)), 1'b0, 1'b1, 1'b0, 1'b0);
    check("ovr_after_81", 64'(buf_overrun), 64'h1);
    check("cnt_after_81", 64'(dut.cnt), 64'(m_cnt));
    bus_cycle(VIC_HI, 12'h000, 1'b0, 1'b0, 1'b0, 1'b1);
    check("ovr_cleared", 64'(buf_overrun), 64'h0);
    bus_cycle(VIC_HRC, 12'h777, 1'b0, 1'b1, 1'b0, 1'b1);
    check("ovr_set_beats_clr", 64'(buf_overrun), 64'(m_ovr));
    bus_cycle(VIC_HI, 12'h000, 1'b0, 1'b0, 1'b0, 1'b1);
    check("ovr_cleared_2", 64'(buf_overrun), 64'h0);

    // line_start coincident with a fetch at cnt=17
    bus_cycle(VIC_HI, 12'h000, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int n = 0; n < 17; n++) bus_cycle(VIC_HRX, 12'h000, 1'b0, 1'b1, 1'b0, 1'b0);
    check("cnt_17", 64'(dut.cnt), 64'd17);
    bus_cycle(VIC_HGC, 12'h312, 1'b0, 1'b1, 1'b1, 1'b0);
    check("ls_fetch_cnt", 64'(dut.cnt), 64'd1);
    bus_cycle(VIC_HRX, 12'h000, 1'b0, 1'b1, 1'b1, 1'b0);
    check("ovr_ls_no_set", 64'(buf_overrun), 64'h0);

    // num_cols shrink below the running count
    for (int n = 0; n < 48; n++) bus_cycle(VIC_HRX, 12'h000, 1'b0, 1'b1, 1'b0, 1'b0);
    num_cols = 7'd40;
    bus_cycle(VIC_HRX, 12'h000, 1'b0, 1'b1, 1'b0, 1'b0);
    check("shrink_wrap_cnt", 64'(dut.cnt), 64'(m_cnt));
    bus_cycle(VIC_HRX, 12'h000, 1'b0, 1'b1, 1'b0, 1'b0);
    check("shrink_wrap_ovr", 64'(buf_overrun), 64'(m_ovr));

    // sprite pointers
    sprite_cnt = 3'd3; sprite_dma = 8'h08;
    bus_cycle(VIC_LP, 12'h02D, 1'b0, 1'b1, 1'b0, 1'b0);
    m_ptr[3] = 8'h2D;
    check("ptr3_dma", sprite_ptr_o, ptr_vec());
    sprite_cnt = 3'd7; sprite_dma = 8'h80;
    bus_cycle(VIC_LP, 12'h0A5, 1'b0, 1'b1, 1'b0, 1'b0);
    m_ptr[7] = 8'hA5;
    check("ptr7_dma", sprite_ptr_o, ptr_vec());
    sprite_cnt = 3'd3; sprite_dma = 8'h00;
    bus_cycle(VIC_LP, 12'h02D, 1'b0, 1'b1, 1'b0, 1'b0);
    m_ptr[3] = 8'hFF;
    check("ptr3_nodma", sprite_ptr_o, ptr_vec());
    sprite_cnt = 3'd5; sprite_dma = 8'hFF;
    bus_cycle(VIC_LP, 12'h033, 1'b1, 1'b1, 1'b0, 1'b0);
    check("ptr_aec_high_no_load", sprite_ptr_o, ptr_vec());

    // g-access on the clear cycle: clear wins for pixels, char_read still loads
    bus_cycle(VIC_HGC, 12'h9AB, 1'b0, 1'b1, 1'b1, 1'b0);
    cycle_num = 7'd55; clk_phi = 1'b1; phi_phase_start_pixel_latch = 1'b1;
    bus_cycle(VIC_LG, 12'h081, 1'b0, 1'b1, 1'b0, 1'b0);
    check("clear_beats_g", 64'(pixels_read), 64'h0);
    check("clear_char_read", 64'(char_read), 64'h9AB);
    cycle_num = 7'd20;
    bus_cycle(VIC_LG, 12'h081, 1'b0, 1'b1, 1'b0, 1'b0);
    check("g_after_clear", 64'(pixels_read), 64'h81);
    clk_phi = 1'b0;
    cycle_num = 7'd55;
    bus_cycle(VIC_HI, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0);
    check("no_clear_phi_low", 64'(pixels_read), 64'h81);
    clk_phi = 1'b1;
    bus_cycle(VIC_HI, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0);
    check("clear_alone", 64'(pixels_read), 64'h0);

    repeat (2) @(negedge clk_dot4x);
    #1;
    check("char_valid_idle", 64'(char_valid), 64'h0);
    check("queue_drained", 64'(exp_q.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bus_access_multi.md
Name: bus_access_multi

Overview:
Parametrised next-generation data-bus capture block for the VIC-II datapath.
- Captures c-access (character/colour), g-access (bitmap) and p-access (sprite pointer) reads from the `dbi` bus.
- Holds a character line buffer whose depth and active column count can be set at runtime, so 40- and 80-column modes share one block.
- Adds a data-valid strobe and a sticky buffer-overrun status flag. s-accesses stay in vic_sprites.

Parameters:
NUM_SPRITES, 8, number of sprite pointer channels (1..8)
MAX_COLS, 80, line buffer depth in entries
CNT_W, 7, column counter width; must satisfy 2**CNT_W >= MAX_COLS
DATA_W, 12, dbi width (colour nibble plus character byte)
PIX_W, 8, low dbi bits carrying character/pixel/pointer data; also pointer width
CLEAR_CYCLE, 55, cycle_num on which pixels_read is zeroed

Ports:
clk_dot4x  in  1  dot clock x4, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
phi_phase_start_dav  in  1  data-valid sample strobe
phi_phase_start_pixel_latch  in  1  pixel latch strobe
clk_phi  in  1  phi2 level
cycle_type  in  4  `VIC_* cycle type code
cycle_num  in  7  raster cycle number
aec  in  1  low = VIC owns the bus
dbi  in  DATA_W  data bus in
idle  in  1  idle state (g-access char forced to 0)
sprite_cnt  in  3  sprite index for p-access
sprite_dma  in  NUM_SPRITES  per-sprite DMA enable
num_cols  in  CNT_W  active columns; 0 or >MAX_COLS means MAX_COLS
line_start  in  1  one-cycle pulse, resets column counter
clr_status  in  1  clears buf_overrun
sprite_ptr_o  out  NUM_SPRITES*PIX_W  flattened pointers, sprite 0 in MSBs
pixels_read  out  PIX_W  last g-access byte
char_read  out  DATA_W  char paired with the last g-access
char_next  out  DATA_W  most recent c-access/cached char
char_valid  out  1  one-cycle strobe; char_next updated this cycle
buf_overrun  out  1  sticky overrun flag

Behaviour:
- Reset (async, rst_n low) clears to 0: every output, every sprite pointer, the column counter `cnt`, the internal `wrapped` flag and buf_overrun. Line buffer contents are not reset.
- Effective column count `ncols` = MAX_COLS if num_cols is 0 or num_cols > MAX_COLS; otherwise num_cols.
- Access event: phi_phase_start_dav high on a clock edge with cycle_type in {HRC, HGC, HRX, HGI}.
- Index `idx` = 0 if line_start is high this edge, else `cnt`. line_start has priority over the held count.
- HRC/HGC (badline fetch):
  - Captured word `w` = {dbi[DATA_W-1:PIX_W], aec ? all-ones : dbi[PIX_W-1:0]}.
  - buf[idx] <= w; char_next <= w.
- HRX/HGI (cached): char_next <= buf[idx], read before any same-edge write.
- char_valid: high for exactly the one cycle after each access event; low otherwise. char_next holds its value between events.
- Counter after an access: cnt <= (idx == ncols-1) ? 0 : idx+1. On wrap, `wrapped` <= 1.
- line_start with no access: cnt <= 0 and wrapped <= 0. line_start with an access also clears `wrapped`, then applies the wrap rule above.
- Overrun: an access event with `wrapped`=1 and no line_start sets buf_overrun. The flag holds until clr_status or reset; a set on the same edge as clr_status wins.
- g-access: on !aec && dav && cycle_type==`VIC_LG`:
  - pixels_read <= dbi[PIX_W-1:0].
  - char_read <= idle ? 0 : char_next, using the value registered before this edge.
- Pixel clear: on clk_phi && cycle_num==CLEAR_CYCLE && pixel_latch, pixels_read <= 0. If it coincides with a g-access load, the clear wins for pixels_read; char_read still loads.
- p-access: on !aec && dav && cycle_type==`VIC_LP` && sprite_cnt<NUM_SPRITES:
  - ptr[sprite_cnt] <= sprite_dma[sprite_cnt] ? dbi[PIX_W-1:0] : all-ones.
  - sprite_cnt >= NUM_SPRITES: no effect.
- Latency: every output is registered and visible the cycle after its qualifying edge. No combinational path from input to output.
- A change to num_cols mid-line takes effect on the next counter update. If cnt >= the new ncols, the next access uses cnt, then wraps to 0 and sets `wrapped`.

Test Plan:
- Reset mid-line: 10 HRC accesses, then rst_n low → cnt=0, char_next=0, sprite_ptr_o=0, buf_overrun=0 immediately (async).
- Badline then cached, num_cols=40: HRC with dbi=12'hA00+n for n=0..39, aec=0; line_start; 40 HGI → char_next sequence 12'hA00..12'hA27, char_valid pulses 40 times, buf_overrun=0.
- aec high during HRC with dbi=12'h5C3 → char_next=12'h5FF and buf[idx]=12'h5FF. LG with idle=1 → char_read=0; with idle=0 → char_read=12'h5FF.
- Overrun, num_cols=0 (MAX_COLS=80): 81 HRC with no line_start → buf_overrun=1 after access 81 and cnt=1. clr_status → buf_overrun=0.
- line_start coincident with HGC, cnt=17, dbi=12'h312 → buf[0]=12'h312, cnt=1.
- Sprites: LP with sprite_cnt=3, dma[3]=1, dbi=8'h2D → ptr3=8'h2D. Same with dma[3]=0 → 8'hFF. LG dbi=8'h81 on cycle 55 coincident with clear → pixels_read=0.
